// File: rtl/yd_timer_pkg.sv
// rtl/yd_timer_pkg.sv - register offsets, bit positions and CTRL layout for yd_dbus_timer
package yd_timer_pkg;

  // Register offsets within the 8-word window
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_CMP    = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN        = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int CTRL_IE        = 2;
  localparam int CTRL_CIE       = 3;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_W   = 8;

  // STATUS bit positions
  localparam int STATUS_EXP  = 0;
  localparam int STATUS_PEND = 1;
  localparam int STATUS_OVF  = 2;
  localparam int STATUS_CMPF = 3;

  typedef struct packed {
    logic [CTRL_PRESC_W-1:0] presc;
    logic                    cie;
    logic                    ie;
    logic                    auto_rl;
    logic                    en;
  } ctrl_t;

  // Bus view of CTRL: prescale in the high byte, unused bits [7:4] read 0
  function automatic logic [15:0] ctrl_pack(input ctrl_t c);
    return {c.presc, 4'b0000, c.cie, c.ie, c.auto_rl, c.en};
  endfunction

endpackage

// File: rtl/yd_timer_presc.sv
// rtl/yd_timer_presc.sv - prescaler counter producing a tick every presc+1 enabled cycles
module yd_timer_presc #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  localparam logic [PRESC_W-1:0] PCNT_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] pcnt;

  // The tick fires on the last cycle of each prescale period; a zero
  // prescale therefore ticks on every enabled cycle.
  assign tick = en && (pcnt == presc);

  // Phase counter: parked at 0 while disabled, wraps to 0 on each tick
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (!en) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_ONE;
    end
  end

endmodule

// File: rtl/yd_dbus_timer.sv
// rtl/yd_dbus_timer.sv - memory-mapped countdown timer with interrupt handshake; compare unit under YD_TIMER_CMP_EN
module yd_dbus_timer
  import yd_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          PRESC_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_din,
  input  logic        d_we,
  output logic [15:0] d_dout,
  output logic        int_vld,
  input  logic        int_rdy,
  output logic        tick_o
);

`ifdef YD_TIMER_CMP_EN
  localparam logic CIE_IMPL = 1'b1;
`else
  localparam logic CIE_IMPL = 1'b0;
`endif

  // Register state
  ctrl_t       ctrl_q;
  logic [15:0] load_q;
  logic [15:0] count_q;
  logic        exp_q;
  logic        ovf_q;
  logic        pend_q;
`ifdef YD_TIMER_CMP_EN
  logic [15:0] cmp_q;
  logic        cmpf_q;
`endif

  // Bus decode
  logic        sel;
  logic [2:0]  off;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_count;
  logic        wr_status;
`ifdef YD_TIMER_CMP_EN
  logic        wr_cmp;
`endif
  logic [15:0] rdata;

  // Timer events
  logic        tick;
  logic        tick_eff;
  logic        expire;
  logic        cmp_hit;
  logic        pend_set;
  logic        exp_clr;
  logic        ovf_clr;

  assign sel       = (d_addr[15:3] == BASE_ADDR[15:3]);
  assign off       = d_addr[2:0];
  assign wr        = d_we && sel;
  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_load   = wr && (off == OFF_LOAD);
  assign wr_count  = wr && (off == OFF_COUNT);
  assign wr_status = wr && (off == OFF_STATUS);
`ifdef YD_TIMER_CMP_EN
  assign wr_cmp    = wr && (off == OFF_CMP);
`endif

  yd_timer_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl_q.en),
    .presc (ctrl_q.presc[PRESC_W-1:0]),
    .tick  (tick)
  );

  assign tick_o = tick;

  // A software COUNT write consumes the tick of the same cycle, so it
  // neither decrements, reloads nor raises any event from that tick.
  assign tick_eff = tick && !wr_count;
  assign expire   = tick_eff && (count_q == 16'h0000);

`ifdef YD_TIMER_CMP_EN
  // Compare matches against the value before this tick's decrement
  assign cmp_hit = tick_eff && (count_q == cmp_q);
`else
  assign cmp_hit = 1'b0;
`endif

  assign pend_set = ctrl_q.ie && (expire || (cmp_hit && ctrl_q.cie));
  assign exp_clr  = wr_status && d_din[STATUS_EXP];
  assign ovf_clr  = wr_status && d_din[STATUS_OVF];

  // Interrupt is offered combinationally so a pending request and a ready
  // core meet in the same cycle; PEND drops on that edge.
  assign int_vld = pend_q && int_rdy;

  // CTRL: software write wins over the one-shot self-disable
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_q.en      <= d_din[CTRL_EN];
      ctrl_q.auto_rl <= d_din[CTRL_AUTO];
      ctrl_q.ie      <= d_din[CTRL_IE];
      ctrl_q.cie     <= d_din[CTRL_CIE] && CIE_IMPL;
      ctrl_q.presc   <= d_din[CTRL_PRESC_LSB +: CTRL_PRESC_W];
    end else if (expire && !ctrl_q.auto_rl) begin
      ctrl_q.en      <= 1'b0;
    end
  end

  // LOAD: plain software register holding the reload value
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q <= '0;
    end else if (wr_load) begin
      load_q <= d_din;
    end
  end

  // COUNT: direct load on write, otherwise count down / reload / park on tick
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= d_din;
    end else if (tick) begin
      if (count_q != 16'h0000) begin
        count_q <= count_q - 16'h0001;
      end else if (ctrl_q.auto_rl) begin
        count_q <= load_q;
      end else begin
        count_q <= 16'h0000;
      end
    end
  end

  // STATUS sticky flags: a new event outranks the write-1-clear. OVF only
  // counts an expiry that lands on an unacknowledged EXP.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      exp_q <= (exp_q && !exp_clr) || expire;
      ovf_q <= (ovf_q && !ovf_clr) || (expire && exp_q && !exp_clr);
    end
  end

  // PEND: cleared by an accepted pulse, re-armed by any coincident event
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_set || (pend_q && !int_rdy);
    end
  end

`ifdef YD_TIMER_CMP_EN
  // CMP register and its sticky match flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q  <= '0;
      cmpf_q <= 1'b0;
    end else begin
      if (wr_cmp) begin
        cmp_q <= d_din;
      end
      cmpf_q <= (cmpf_q && !(wr_status && d_din[STATUS_CMPF])) || cmp_hit;
    end
  end
`endif

  // Read mux over the current register state; unmapped offsets read 0
  always_comb begin
    rdata = 16'h0000;
    case (off)
      OFF_CTRL:   rdata = ctrl_pack(ctrl_q);
      OFF_LOAD:   rdata = load_q;
      OFF_COUNT:  rdata = count_q;
      OFF_STATUS: begin
        rdata[STATUS_EXP]  = exp_q;
        rdata[STATUS_PEND] = pend_q;
        rdata[STATUS_OVF]  = ovf_q;
`ifdef YD_TIMER_CMP_EN
        rdata[STATUS_CMPF] = cmpf_q;
`endif
      end
`ifdef YD_TIMER_CMP_EN
      OFF_CMP:    rdata = cmp_q;
`endif
      default:    rdata = 16'h0000;
    endcase
  end

  // Registered read port; drives 0 when unselected so it can be OR-ed
  always_ff @(posedge clk) begin
    if (rst) begin
      d_dout <= '0;
    end else if (sel) begin
      d_dout <= rdata;
    end else begin
      d_dout <= '0;
    end
  end

endmodule
